uart_mmio_responder: RTL and testbench
======================================

# uart_mmio_responder

Memory-mapped UART peripheral that answers CPU loads and stores on the UART register addresses, sitting between the address decoder/read mux and the UART_TX/UART_RX serial engines. It buffers outgoing bytes in a TX FIFO and drains them to UART_TX with a handshake state machine. It also captures bytes from UART_RX into an RX FIFO and returns them to the CPU together with a status word. All bus enables are edge-detected, so an access held high for many clk_in cycles counts exactly once.

## Interface
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of two, ≥2)
- clk_in  in  1  single clock for bus side and serial-engine handshake
- reset  in  1  asynchronous, active-high; one clock, no other reset
- tx_write_en  in  1  CPU store to TX data register
- rx_read_en  in  1  CPU load from RX data register
- status_read_en  in  1  CPU load from status register
- ctrl_write_en  in  1  CPU store to control register
- write_data  in  32  CPU store data
- read_data  out  32  load data; 0 when no read enable
- tx_busy  in  1  UART_TX busy
- tx_start  out  1  one-cycle start pulse to UART_TX
- tx_data  out  8  byte for UART_TX, valid with tx_start
- rx_data  in  8  UART_RX byte
- rx_data_ready  in  1  UART_RX byte-available flag
- rx_data_clear  out  1  one-cycle acknowledge to UART_RX

## Operation
- Access events: tx/ctrl write = rising edge of enable; RX pop = falling edge of rx_read_en (head stays stable while CPU reads).
- TX write: push write_data[7:0]; if full, drop and set sticky tx_drop.
- read_data: rx_read_en → {24'b0, RX head} (0 if empty, no pop, no flag); status_read_en → status; else 0.
- Status: [0] rx_not_empty, [1] tx_full, [2] tx_active (FIFO non-empty or FSM≠IDLE or tx_busy), [3] rx_overrun, [4] tx_drop, [5] loopback, [15:8] rx_count, [23:16] tx_count; others 0.
- Control write: bit0 clears rx_overrun/tx_drop; bit1 flushes both FIFOs and returns the FSM to IDLE; bit2 loopback (see Configuration).
- RX capture: rising edge of rx_data_ready → push rx_data, pulse rx_data_clear next cycle; if full, drop byte, set rx_overrun, still pulse clear.
- Drain FSM: IDLE → START when TX non-empty and !tx_busy. START drives tx_start=1 and tx_data=head, pops, → WAIT_BUSY. WAIT_BUSY → WAIT_DONE on tx_busy=1, or after 4 cycles with no busy. WAIT_DONE → IDLE on tx_busy=0.

## Timing
- Reset values: read_data 0, tx_start 0, tx_data 0, rx_data_clear 0, FIFOs empty, flags 0, loopback 0, FSM IDLE, edge registers 0.
- Enable high in cycle N → TX push at edge ending N, status reflects it in N+1, START in N+1 if idle, tx_start high exactly one cycle.
- Back-to-back bytes: one START per IDLE visit; minimum 3 cycles between tx_start pulses.
- Simultaneous push and pop on a full or empty FIFO: both succeed, count unchanged (empty: push only).
- Flush together with TX write or RX capture: flush wins, byte discarded silently.
- Counts saturate at DEPTH; pointers wrap modulo DEPTH.
- Reset mid-transfer: everything returns to reset values immediately; UART_TX is reset by the same signal.

## Configuration
- UART_MMIO_LOOPBACK_EN defined: control bit2 sets loopback. While set, the FSM moves the TX head straight into the RX FIFO, one byte per cycle when RX is not full. tx_start stays 0, and UART_RX captures are ignored with no clear pulse.
- Undefined: bit2 ignored, status[5] reads 0, no loopback logic synthesized.

## Structure
- Package uart_mmio_pkg: FSM state enum (IDLE, START, WAIT_BUSY, WAIT_DONE), status/control bit-index localparams, WAIT_BUSY timeout constant (4).
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, count, head), instantiated for TX and RX.

## Test plan
- Write 0x41, 0x42 with tx_busy model (busy 1 cycle after start, 10 cycles long) → two tx_start pulses carrying 0x41 then 0x42, status[2] drops after second busy ends.
- Write 9 bytes with tx_busy held 1 → tx_count=8, status[1]=1, status[4]=1, ninth byte never sent.
- Pulse rx_data_ready with 0x5A, then read RX with enable held 50 cycles → read_data=0x5A throughout, one rx_data_clear, rx_count 1→0 after enable falls.
- 9 RX bytes without reads → rx_count=8, status[3]=1; control write 0x1 → status[3]=0, data kept.
- With UART_MMIO_LOOPBACK_EN, control 0x4, write 0x33 → no tx_start, RX head=0x33.
- Assert reset during WAIT_DONE with 3 bytes queued → all outputs 0, tx_count=0 next cycle.

Source files
------------

// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
// Shared definitions for the memory-mapped UART responder:
//   - tx_state_t   : drain state machine states (IDLE, START, WAIT_BUSY, WAIT_DONE)
//   - STAT_*       : bit positions inside the status word
//   - CTRL_*       : bit positions inside the control register
//   - BUSY_TIMEOUT : cycles WAIT_BUSY waits for tx_busy before giving up
package uart_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

    localparam int unsigned STAT_RX_NOT_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL      = 1;
    localparam int unsigned STAT_TX_ACTIVE    = 2;
    localparam int unsigned STAT_RX_OVERRUN   = 3;
    localparam int unsigned STAT_TX_DROP      = 4;
    localparam int unsigned STAT_LOOPBACK     = 5;
    localparam int unsigned STAT_RX_COUNT_LSB = 8;
    localparam int unsigned STAT_TX_COUNT_LSB = 16;

    localparam int unsigned CTRL_CLEAR_FLAGS  = 0;
    localparam int unsigned CTRL_FLUSH        = 1;
    localparam int unsigned CTRL_LOOPBACK     = 2;

    localparam int unsigned BUSY_TIMEOUT      = 4;

endpackage

// File: rtl/uart_mmio_responder_fifo.sv
// sync_fifo
// Single-clock FIFO used for both the TX and RX byte queues.
//   clk_in, reset : clock, asynchronous active-high reset
//   push, wr_data : enqueue request and data (accepted when not full, or
//                   when full but popping in the same cycle)
//   pop           : dequeue request (ignored when empty)
//   flush         : empties the FIFO; overrides push and pop
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
//   head          : oldest entry (undefined when empty)
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder
// CPU-facing UART register block between the bus decoder and the UART_TX /
// UART_RX serial engines. Stores go into a TX FIFO drained by a handshake
// state machine; bytes from UART_RX are queued in an RX FIFO for CPU loads.
// All bus enables are edge-detected so a long-held access counts once.
//
// Ports:
//   clk_in, reset       : clock, asynchronous active-high reset
//   tx_write_en         : store to TX data register (rising edge pushes)
//   rx_read_en          : load from RX data register (falling edge pops)
//   status_read_en      : load from status register
//   ctrl_write_en       : store to control register (rising edge acts)
//   write_data          : store data
//   read_data           : load data, 0 when no read enable is active
//   tx_busy             : UART_TX busy
//   tx_start, tx_data   : one-cycle start pulse and byte for UART_TX
//   rx_data             : byte from UART_RX
//   rx_data_ready       : UART_RX byte available (rising edge captures)
//   rx_data_clear       : one-cycle acknowledge to UART_RX
//
// Build option: define UART_MMIO_LOOPBACK_EN to add the internal loopback
// path (control bit 2); without it the bit is ignored and status[5] reads 0.
module uart_mmio_responder
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        tx_write_en,
    input  logic        rx_read_en,
    input  logic        status_read_en,
    input  logic        ctrl_write_en,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    output logic        rx_data_clear
);

    localparam int unsigned TX_CW  = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW  = $clog2(RX_DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(BUSY_TIMEOUT);

    // Edge detection
    logic tx_we_q, rx_re_q, ctrl_we_q, rdy_q;
    logic tx_wr_evt, rx_pop_evt, ctrl_evt, rdy_evt;
    logic flush, clr_flags;

    // FIFO plumbing
    logic             tx_pop, tx_full, tx_empty;
    logic [TX_CW-1:0] tx_count;
    logic [7:0]       tx_head;
    logic             rx_push, rx_full, rx_empty;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       rx_head, rx_wdata;

    // Control / status
    logic        loopback, lb_xfer, rx_cap;
    logic        rx_overrun, tx_drop, tx_drop_set, rx_ovr_set;
    logic [31:0] status;

    tx_state_t   state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt;

    logic unused_ok;
    assign unused_ok = ^write_data[31:8];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            tx_we_q   <= 1'b0;
            rx_re_q   <= 1'b0;
            ctrl_we_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            tx_we_q   <= tx_write_en;
            rx_re_q   <= rx_read_en;
            ctrl_we_q <= ctrl_write_en;
            rdy_q     <= rx_data_ready;
        end
    end

    assign tx_wr_evt  = tx_write_en & ~tx_we_q;
    // Pop on the falling edge so the head stays put for the whole load.
    assign rx_pop_evt = ~rx_read_en & rx_re_q;
    assign ctrl_evt   = ctrl_write_en & ~ctrl_we_q;
    assign rdy_evt    = rx_data_ready & ~rdy_q;
    assign flush      = ctrl_evt & write_data[CTRL_FLUSH];
    assign clr_flags  = ctrl_evt & write_data[CTRL_CLEAR_FLAGS];

`ifdef UART_MMIO_LOOPBACK_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            loopback <= 1'b0;
        else if (ctrl_evt)
            loopback <= write_data[CTRL_LOOPBACK];
    end
`else
    assign loopback = 1'b0;
`endif

    // UART_RX captures are ignored while loopback owns the RX FIFO input.
    assign rx_cap   = rdy_evt & ~loopback;
    assign rx_push  = loopback ? lb_xfer : rx_cap;
    assign rx_wdata = loopback ? tx_head : rx_data;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push    (tx_wr_evt),
        .pop     (tx_pop),
        .flush   (flush),
        .wr_data (write_data[7:0]),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .head    (tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push    (rx_push),
        .pop     (rx_pop_evt),
        .flush   (flush),
        .wr_data (rx_wdata),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count),
        .head    (rx_head)
    );

    // A flushed byte is discarded silently, so it never raises a drop flag.
    assign tx_drop_set = tx_wr_evt & ~flush & tx_full & ~tx_pop;
    assign rx_ovr_set  = rx_cap & ~flush & rx_full & ~rx_pop_evt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            rx_overrun    <= 1'b0;
            tx_drop       <= 1'b0;
            rx_data_clear <= 1'b0;
        end else begin
            rx_data_clear <= rx_cap;
            if (clr_flags) begin
                rx_overrun <= 1'b0;
                tx_drop    <= 1'b0;
            end
            if (tx_drop_set) tx_drop    <= 1'b1;
            if (rx_ovr_set)  rx_overrun <= 1'b1;
        end
    end

    // Drain FSM: state register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_q == WAIT_BUSY) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

    // Drain FSM: next state. IDLE also looks at the write event in flight so
    // a store into an idle, empty FIFO reaches START in the following cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:
                    if (!loopback && !tx_busy && (!tx_empty || tx_wr_evt))
                        state_d = START;
                START:
                    state_d = WAIT_BUSY;
                WAIT_BUSY:
                    if (tx_busy || wait_cnt == WAIT_W'(BUSY_TIMEOUT - 1))
                        state_d = WAIT_DONE;
                WAIT_DONE:
                    if (!tx_busy)
                        state_d = IDLE;
                default:
                    state_d = IDLE;
            endcase
        end
    end

    // Drain FSM: outputs
    always_comb begin
        tx_start = 1'b0;
        tx_data  = '0;
        tx_pop   = 1'b0;
        lb_xfer  = 1'b0;
        case (state_q)
            START: begin
                tx_start = 1'b1;
                tx_data  = tx_head;
                tx_pop   = 1'b1;
            end
            IDLE: begin
                lb_xfer = loopback & ~tx_empty & (~rx_full | rx_pop_evt);
                tx_pop  = lb_xfer;
            end
            default: ;
        endcase
    end

    always_comb begin
        status = '0;
        status[STAT_RX_NOT_EMPTY] = ~rx_empty;
        status[STAT_TX_FULL]      = tx_full;
        status[STAT_TX_ACTIVE]    = ~tx_empty | (state_q != IDLE) | tx_busy;
        status[STAT_RX_OVERRUN]   = rx_overrun;
        status[STAT_TX_DROP]      = tx_drop;
        status[STAT_LOOPBACK]     = loopback;
        status[STAT_RX_COUNT_LSB +: 8] = 8'(rx_count);
        status[STAT_TX_COUNT_LSB +: 8] = 8'(tx_count);
    end

    always_comb begin
        read_data = '0;
        if (rx_read_en)
            read_data = {24'h0, rx_empty ? 8'h00 : rx_head};
        else if (status_read_en)
            read_data = status;
    end

endmodule

// File: tb/tb_uart_mmio_responder.sv
module tb_uart_mmio_responder;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        tx_write_en = 1'b0, rx_read_en = 1'b0, status_read_en = 1'b0, ctrl_write_en = 1'b0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data = '0;
    logic        rx_data_ready = 1'b0;
    logic        rx_data_clear;

    always #5 clk_in = ~clk_in;

    uart_mmio_responder #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_in         (clk_in),
        .reset          (reset),
        .tx_write_en    (tx_write_en),
        .rx_read_en     (rx_read_en),
        .status_read_en (status_read_en),
        .ctrl_write_en  (ctrl_write_en),
        .write_data     (write_data),
        .read_data      (read_data),
        .tx_busy        (tx_busy),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_data_clear  (rx_data_clear)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    logic        busy_auto = 1'b0;
    int          busy_left = 0;
    logic [7:0]  starts[$];
    int          start_cyc[$];
    int unsigned clears = 0;

    // Advance one clock. Records UART_TX starts / RX clears seen in the cycle
    // that ends, and models UART_TX: busy from the cycle after a start, 10 cycles.
    task automatic tick();
        logic saw;
        saw = tx_start;
        if (tx_start) begin
            starts.push_back(tx_data);
            start_cyc.push_back(cyc);
        end
        if (rx_data_clear) clears++;
        @(posedge clk_in);
        #2;
        cyc++;
        if (busy_auto) begin
            if (saw) busy_left = 10;
            else if (busy_left > 0) busy_left--;
            tx_busy = (busy_left > 0);
        end
    endtask

    task automatic read_status(output logic [31:0] s);
        status_read_en = 1'b1;
        #1;
        s = read_data;
        status_read_en = 1'b0;
        #1;
    endtask

    task automatic apply_reset();
        tx_write_en = 0; rx_read_en = 0; status_read_en = 0; ctrl_write_en = 0;
        rx_data_ready = 0; write_data = '0; busy_auto = 0; busy_left = 0; tx_busy = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        starts.delete(); start_cyc.delete(); clears = 0;
    endtask

    task automatic cpu_tx_write(input logic [7:0] b);
        write_data = {24'h0, b}; tx_write_en = 1'b1; tick();
        tx_write_en = 1'b0; tick();
    endtask

    task automatic ctrl_write(input logic [31:0] v);
        write_data = v; ctrl_write_en = 1'b1; tick();
        ctrl_write_en = 1'b0; tick();
    endtask

    task automatic rx_feed(input logic [7:0] b);
        rx_data = b; rx_data_ready = 1'b1; tick();
        rx_data_ready = 1'b0; tick();
    endtask

    task automatic test_reset();
        logic [31:0] s;
        reset = 1'b1;
        tick();
        #1;
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_vec++; if (rx_data_clear !== 1'b0) begin n_err++; $display("FAIL reset_rx_clear: got %b expected 0", rx_data_clear); end
        n_vec++; if (read_data !== 32'h0) begin n_err++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
        reset = 1'b0;
        tick();
        read_status(s);
        n_vec++; if (s !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", s); end
    endtask

    task automatic test_tx_basic();
        logic [31:0] s;
        int s1, first_idle;
        apply_reset();
        busy_auto = 1'b1;
        write_data = 32'h41; tx_write_en = 1'b1; tick();
        n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL tx_first_start: got %b/%h expected 1/41", tx_start, tx_data); end
        s1 = cyc;
        tx_write_en = 1'b0; tick();
        write_data = 32'h42; tx_write_en = 1'b1; tick();
        tx_write_en = 1'b0;
        for (int i = 0; i < 60 && starts.size() < 2; i++) tick();
        n_vec++; if (starts.size() != 2) begin n_err++; $display("FAIL tx_start_count: got %0d expected 2", starts.size()); end
        if (starts.size() == 2) begin
            n_vec++; if (starts[0] !== 8'h41 || starts[1] !== 8'h42) begin n_err++; $display("FAIL tx_bytes: got %h %h expected 41 42", starts[0], starts[1]); end
            n_vec++; if (start_cyc[0] != s1) begin n_err++; $display("FAIL tx_start1_cycle: got %0d expected %0d", start_cyc[0], s1); end
            n_vec++; if (start_cyc[1] != s1 + 13) begin n_err++; $display("FAIL tx_start2_cycle: got %0d expected %0d", start_cyc[1], s1 + 13); end
            first_idle = -1;
            for (int i = 0; i < 40; i++) begin
                read_status(s);
                if (!s[2]) begin first_idle = cyc; break; end
                tick();
            end
            n_vec++; if (first_idle != start_cyc[1] + 12) begin n_err++; $display("FAIL tx_active_drop: got cycle %0d expected %0d", first_idle, start_cyc[1] + 12); end
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] s;
        logic [7:0] b[9];
        apply_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b[i] = 8'($urandom);
            cpu_tx_write(b[i]);
        end
        read_status(s);
        n_vec++; if (s[23:16] !== 8'd8) begin n_err++; $display("FAIL ovf_tx_count: got %0d expected 8", s[23:16]); end
        n_vec++; if (s[1] !== 1'b1) begin n_err++; $display("FAIL ovf_tx_full: got %b expected 1", s[1]); end
        n_vec++; if (s[4] !== 1'b1) begin n_err++; $display("FAIL ovf_tx_drop: got %b expected 1", s[4]); end
        n_vec++; if (starts.size() != 0) begin n_err++; $display("FAIL ovf_sent_while_busy: got %0d expected 0", starts.size()); end
        tx_busy = 1'b0; busy_auto = 1'b1;
        for (int i = 0; i < 150; i++) tick();
        n_vec++; if (starts.size() != 8) begin n_err++; $display("FAIL ovf_sent_count: got %0d expected 8", starts.size()); end
        for (int i = 0; i < 8 && i < starts.size(); i++) begin
            n_vec++; if (starts[i] !== b[i]) begin n_err++; $display("FAIL ovf_byte%0d: got %h expected %h", i, starts[i], b[i]); end
        end
        ctrl_write(32'h1);
        read_status(s);
        n_vec++; if (s[4] !== 1'b0) begin n_err++; $display("FAIL ovf_drop_clear: got %b expected 0", s[4]); end
    endtask

    task automatic test_rx_hold();
        logic [31:0] s;
        apply_reset();
        rx_data = 8'h5A; rx_data_ready = 1'b1; tick();
        n_vec++; if (rx_data_clear !== 1'b1) begin n_err++; $display("FAIL rx_clear_pulse: got %b expected 1", rx_data_clear); end
        rx_data_ready = 1'b0; tick();
        n_vec++; if (rx_data_clear !== 1'b0) begin n_err++; $display("FAIL rx_clear_width: got %b expected 0", rx_data_clear); end
        rx_read_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            n_vec++; if (read_data !== 32'h5A) begin n_err++; $display("FAIL rx_hold_data: cycle %0d got %h expected 5a", i, read_data); end
            tick();
        end
        rx_read_en = 1'b0;
        read_status(s);
        n_vec++; if (s[15:8] !== 8'd1) begin n_err++; $display("FAIL rx_count_before_pop: got %0d expected 1", s[15:8]); end
        tick();
        read_status(s);
        n_vec++; if (s[15:8] !== 8'd0 || s[0] !== 1'b0) begin n_err++; $display("FAIL rx_count_after_pop: got %h expected 0", s[15:8]); end
        tick();
        n_vec++; if (clears != 1) begin n_err++; $display("FAIL rx_clear_total: got %0d expected 1", clears); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] s;
        logic [7:0] b[9];
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            b[i] = 8'($urandom);
            rx_feed(b[i]);
        end
        read_status(s);
        n_vec++; if (s[15:8] !== 8'd8 || s[3] !== 1'b1) begin n_err++; $display("FAIL ovr_set: got count %0d ovr %b expected 8 1", s[15:8], s[3]); end
        ctrl_write(32'h1);
        read_status(s);
        n_vec++; if (s[15:8] !== 8'd8 || s[3] !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got count %0d ovr %b expected 8 0", s[15:8], s[3]); end
        for (int i = 0; i < 8; i++) begin
            rx_read_en = 1'b1; #1;
            n_vec++; if (read_data !== {24'h0, b[i]}) begin n_err++; $display("FAIL ovr_data%0d: got %h expected %h", i, read_data, b[i]); end
            tick();
            rx_read_en = 1'b0; tick();
        end
        rx_read_en = 1'b1; #1;
        n_vec++; if (read_data !== 32'h0) begin n_err++; $display("FAIL rx_empty_read: got %h expected 0", read_data); end
        tick();
        rx_read_en = 1'b0; tick();
    endtask

    task automatic test_flush();
        logic [31:0] s;
        apply_reset();
        tx_busy = 1'b1;
        cpu_tx_write(8'h11); cpu_tx_write(8'h22); cpu_tx_write(8'h33);
        rx_feed(8'hA1); rx_feed(8'hA2);
        ctrl_write(32'h2);
        read_status(s);
        n_vec++; if (s[23:16] !== 8'd0 || s[15:8] !== 8'd0) begin n_err++; $display("FAIL flush_counts: got tx %0d rx %0d expected 0 0", s[23:16], s[15:8]); end
        tx_busy = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_vec++; if (starts.size() != 0) begin n_err++; $display("FAIL flush_no_send: got %0d expected 0", starts.size()); end
    endtask

    task automatic test_random_rx();
        logic [7:0]  q[$];
        logic        ovr = 1'b0, prev_rdy = 1'b0, prev_rd = 1'b0, exp_clear = 1'b0;
        logic        cap, pop;
        logic [31:0] exp_rd, exp_st;
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            rx_data_ready = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rx_read_en = ~rx_read_en;
            status_read_en = !rx_read_en && ($urandom_range(0, 1) == 1);
            #1;
            exp_st = '0;
            exp_st[0] = (q.size() > 0);
            exp_st[3] = ovr;
            exp_st[15:8] = 8'(q.size());
            if (rx_read_en) exp_rd = (q.size() > 0) ? {24'h0, q[0]} : 32'h0;
            else if (status_read_en) exp_rd = exp_st;
            else exp_rd = 32'h0;
            n_vec++; if (read_data !== exp_rd) begin n_err++; $display("FAIL rand_read_data: step %0d got %h expected %h", i, read_data, exp_rd); end
            n_vec++; if (rx_data_clear !== exp_clear) begin n_err++; $display("FAIL rand_rx_clear: step %0d got %b expected %b", i, rx_data_clear, exp_clear); end
            cap = rx_data_ready && !prev_rdy;
            pop = !rx_read_en && prev_rd && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < 8) q.push_back(rx_data);
                else ovr = 1'b1;
            end
            exp_clear = cap;
            prev_rdy = rx_data_ready;
            prev_rd = rx_read_en;
            tick();
        end
        status_read_en = 1'b0; rx_read_en = 1'b0; rx_data_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        logic [7:0]  exp[$];
        apply_reset();
        busy_auto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp.push_back(8'($urandom));
            cpu_tx_write(exp[i]);
        end
        for (int i = 0; i < 200 && starts.size() < 6; i++) tick();
        n_vec++; if (starts.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d expected 6", starts.size()); end
        for (int i = 0; i < 6 && i < starts.size(); i++) begin
            n_vec++; if (starts[i] !== exp[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h expected %h", i, starts[i], exp[i]); end
            if (i > 0) begin
                n_vec++; if (start_cyc[i] - start_cyc[i-1] < 3) begin n_err++; $display("FAIL b2b_gap%0d: got %0d expected >=3", i, start_cyc[i] - start_cyc[i-1]); end
            end
        end
        read_status(s);
        n_vec++; if (s[4] !== 1'b0) begin n_err++; $display("FAIL b2b_no_drop: got %b expected 0", s[4]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        apply_reset();
        busy_auto = 1'b1;
        cpu_tx_write(8'h01); cpu_tx_write(8'h02); cpu_tx_write(8'h03); cpu_tx_write(8'h04);
        read_status(s);
        n_vec++; if (s[23:16] !== 8'd3) begin n_err++; $display("FAIL mid_queued: got %0d expected 3", s[23:16]); end
        reset = 1'b1;
        busy_auto = 1'b0; busy_left = 0; tx_busy = 1'b0;
        #1;
        n_vec++; if ({tx_start, tx_data, rx_data_clear} !== 10'h0) begin n_err++; $display("FAIL mid_outputs: got %b/%h/%b expected 0", tx_start, tx_data, rx_data_clear); end
        n_vec++; if (read_data !== 32'h0) begin n_err++; $display("FAIL mid_read_data: got %h expected 0", read_data); end
        tick();
        read_status(s);
        n_vec++; if (s !== 32'h0) begin n_err++; $display("FAIL mid_status: got %h expected 0", s); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        logic [31:0] s;
        apply_reset();
        ctrl_write(32'h4);
        read_status(s);
`ifdef UART_MMIO_LOOPBACK_EN
        n_vec++; if (s[5] !== 1'b1) begin n_err++; $display("FAIL lb_status: got %b expected 1", s[5]); end
        cpu_tx_write(8'h33);
        for (int i = 0; i < 5; i++) tick();
        n_vec++; if (starts.size() != 0) begin n_err++; $display("FAIL lb_no_start: got %0d expected 0", starts.size()); end
        rx_read_en = 1'b1; #1;
        n_vec++; if (read_data !== 32'h33) begin n_err++; $display("FAIL lb_rx_head: got %h expected 33", read_data); end
        tick();
        rx_read_en = 1'b0; tick();
`else
        n_vec++; if (s[5] !== 1'b0) begin n_err++; $display("FAIL lb_status: got %b expected 0", s[5]); end
`endif
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_rx_hold();
        test_rx_overrun();
        test_flush();
        test_random_rx();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
